// File: rtl/unary_ctrl_pkg.sv
// Shared types for the unary-unit arbiter: controller state encoding and
// a width helper used for requester-index ports.
package unary_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first set request at or after
// ptr (wrapping) wins.
module rr_arbiter
  import unary_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_id,
  output logic                any
);

  int best_dist;

  // NOTE: every output of a combinational block is given a default first, so
  // no path through the block leaves a value held and no latch is inferred.
  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    any       = |req;
    best_dist = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Distance of requester i from the priority pointer, going upward.
      if (req[i] && (((i + NUM_REQ - int'(ptr)) % NUM_REQ) < best_dist)) begin
        best_dist = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
        gnt       = '0;
        gnt[i]    = 1'b1;
        gnt_id    = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/unary_unit_arbiter.sv
// Shares one bit-serial unary unit among NUM_REQ requesters: clears the unit,
// streams INPUT_WIDTH owner bits in, forwards INPUT_WIDTH result bits tagged
// with the owner, and closes each stream with a done pulse.
module unary_unit_arbiter
  import unary_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
  parameter int ID_WIDTH    = id_width(NUM_REQ),
  parameter int TIMEOUT     = 4 * INPUT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  req_bit,
  output logic [NUM_REQ-1:0]  grant,
  output logic [NUM_REQ-1:0]  bit_take,
  output logic                out_bit,
  output logic                out_valid,
  output logic [ID_WIDTH-1:0] out_id,
  output logic                done,
  output logic                err,
  output logic                unit_reset,
  output logic                unit_ready,
  output logic                unit_a,
  input  logic                unit_valid,
  input  logic                unit_y
);

  localparam int TIMER_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_LAST   = COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = TIMER_WIDTH'(TIMEOUT);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT - 1);
  localparam logic [ID_WIDTH-1:0]    ID_LAST    = ID_WIDTH'(NUM_REQ - 1);

  state_t state, state_next;

  logic [ID_WIDTH-1:0]    owner;
  logic [NUM_REQ-1:0]     owner_gnt;
  logic [ID_WIDTH-1:0]    rr_ptr;
  logic [COUNT_WIDTH-1:0] in_cnt;
  logic [COUNT_WIDTH-1:0] out_cnt;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   err_q;
  logic                   out_bit_q;
  logic                   out_valid_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_WIDTH-1:0] arb_id;
  logic                arb_any;

  logic in_stream;
  logic beat;
  logic last_beat;
  logic timed_out;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  assign in_stream = (state == STREAM);
  assign beat      = in_stream && unit_valid;
  // The beat arriving this cycle counts toward completion.
  assign last_beat = beat && (out_cnt >= CNT_LAST);
  assign timed_out = in_stream && (timer == TIMER_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_any) state_next = CLEAR;
      CLEAR:   state_next = STREAM;
      STREAM:  if (last_beat || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= '0;
      owner_gnt   <= '0;
      rr_ptr      <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      timer       <= '0;
      err_q       <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      out_valid_q <= beat;
      out_bit_q   <= beat && unit_y;
      case (state)
        IDLE: begin
          if (arb_any) begin
            owner     <= arb_id;
            owner_gnt <= arb_gnt;
          end
        end
        CLEAR: begin
          in_cnt  <= '0;
          out_cnt <= '0;
          timer   <= '0;
          err_q   <= 1'b0;
        end
        STREAM: begin
          if (unit_ready) in_cnt <= in_cnt + COUNT_WIDTH'(1);
          if (beat && (out_cnt < CNT_MAX)) out_cnt <= out_cnt + COUNT_WIDTH'(1);
          if (timer < TIMER_MAX) timer <= timer + TIMER_WIDTH'(1);
          // A stream that completes on its final allowed cycle is not an error.
          if (timed_out && !last_beat) err_q <= 1'b1;
        end
        DONE: begin
          rr_ptr    <= (owner == ID_LAST) ? '0 : owner + ID_WIDTH'(1);
          owner_gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign grant      = (state == CLEAR || in_stream) ? owner_gnt : '0;
  assign unit_ready = in_stream && (in_cnt < CNT_MAX);
  assign bit_take   = unit_ready ? owner_gnt : '0;
  assign unit_a     = unit_ready && |(req_bit & owner_gnt);
  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign done       = (state == DONE);
  assign err        = done && err_q;
  assign out_id     = (out_valid_q || done) ? owner : '0;
  assign unit_reset = reset && (state != CLEAR);

endmodule

// File: tb/tb_unary_unit_arbiter.sv
// Directed bench for unary_unit_arbiter with a 2-cycle divide-by-two unary
// unit model: a vector table of single streams plus multi-cycle sequences.
module tb_unary_unit_arbiter;
  import unary_ctrl_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int INPUT_WIDTH  = 8;
  localparam int ID_WIDTH     = 2;
  localparam int TIMEOUT      = 32;
  localparam int UNIT_LATENCY = 2;
  localparam int NORMAL_LAT   = INPUT_WIDTH + UNIT_LATENCY + 1;  // CLEAR to DONE
  localparam int TIMEOUT_LAT  = TIMEOUT + 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NUM_REQ-1:0]  req = '0;
  logic [NUM_REQ-1:0]  req_bit = '0;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  bit_take;
  logic                out_bit;
  logic                out_valid;
  logic [ID_WIDTH-1:0] out_id;
  logic                done;
  logic                err;
  logic                unit_reset;
  logic                unit_ready;
  logic                unit_a;
  logic                unit_valid;
  logic                unit_y;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  unary_unit_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .INPUT_WIDTH (INPUT_WIDTH),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_bit    (req_bit),
    .grant      (grant),
    .bit_take   (bit_take),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .done       (done),
    .err        (err),
    .unit_reset (unit_reset),
    .unit_ready (unit_ready),
    .unit_a     (unit_a),
    .unit_valid (unit_valid),
    .unit_y     (unit_y)
  );

  // Divide-by-two unary unit: passes every other 1, two-cycle latency.
  logic unit_mute = 1'b0;
  logic v0, v1, y0, y1, tog;
  always @(posedge clk) begin
    if (!unit_reset) begin
      v0 <= 1'b0; v1 <= 1'b0; y0 <= 1'b0; y1 <= 1'b0; tog <= 1'b0;
    end else begin
      v0 <= unit_ready;
      y0 <= unit_ready & unit_a & ~tog;
      if (unit_ready & unit_a) tog <= ~tog;
      v1 <= v0;
      y1 <= y0;
    end
  end
  assign unit_valid = v1 & ~unit_mute;
  assign unit_y     = y1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [ID_WIDTH-1:0] oh_index(input logic [NUM_REQ-1:0] v);
    logic [ID_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = ID_WIDTH'(i);
    return r;
  endfunction

  typedef struct {
    logic [NUM_REQ-1:0]  g;
    logic [ID_WIDTH-1:0] id;
    logic                e;
    logic                seen_done;
    int takes, beats, ones;
    int t_clear, t_first, t_last, t_done;
    int bad;
  } res_t;

  // Follows one stream from its CLEAR to its DONE, sampling on falling edges.
  task automatic collect(input logic drop, input logic [NUM_REQ-1:0] new_req, output res_t r);
    r.g = '0; r.id = '0; r.e = 1'b0; r.seen_done = 1'b0;
    r.takes = 0; r.beats = 0; r.ones = 0;
    r.t_clear = -1; r.t_first = -1; r.t_last = -1; r.t_done = -1; r.bad = 0;
    for (int k = 0; k < 200 && !r.seen_done; k++) begin
      @(negedge clk);
      if (grant != '0 && r.g == '0) begin
        r.g = grant;
        r.t_clear = cyc;
        if (drop) req = new_req;
      end
      if (grant != '0 && grant != r.g) r.bad++;
      if (bit_take != '0) begin
        if (bit_take != r.g) r.bad++;
        if (r.t_first < 0) r.t_first = cyc;
        r.t_last = cyc;
        r.takes++;
      end
      if (out_valid) begin
        r.beats++;
        r.ones += int'(out_bit);
        if (out_id != oh_index(r.g)) r.bad++;
      end
      if (done) begin
        r.seen_done = 1'b1;
        r.id = out_id;
        r.e = err;
        r.t_done = cyc;
      end
    end
  endtask

  typedef struct {
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  req_bit;
    logic                mute;
    logic [ID_WIDTH-1:0] exp_id;
    int                  exp_beats;
    int                  exp_ones;
    logic                exp_err;
    int                  exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    res_t r, prev;
    int   t_req;
    int   wait_n;
    int   done_cnt;

    // Rows start with rr_ptr = 1 (left there by the held-request sequence).
    vecs[0] = '{4'b0001, 4'b1111, 1'b0, 2'd0, 8, 4, 1'b0, NORMAL_LAT};
    vecs[1] = '{4'b0001, 4'b0000, 1'b0, 2'd0, 8, 0, 1'b0, NORMAL_LAT};
    vecs[2] = '{4'b0110, 4'b1111, 1'b0, 2'd1, 8, 4, 1'b0, NORMAL_LAT};
    vecs[3] = '{4'b0100, 4'b1011, 1'b0, 2'd2, 8, 0, 1'b0, NORMAL_LAT};
    vecs[4] = '{4'b1001, 4'b1000, 1'b0, 2'd3, 8, 4, 1'b0, NORMAL_LAT};
    vecs[5] = '{4'b1010, 4'b0010, 1'b1, 2'd1, 0, 0, 1'b1, TIMEOUT_LAT};
    vecs[6] = '{4'b0101, 4'b0101, 1'b0, 2'd2, 8, 4, 1'b0, NORMAL_LAT};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset outputs", {grant, bit_take, out_bit, out_valid, out_id, done, err,
                            unit_ready, unit_a}, '0);
    check("reset unit_reset", unit_reset, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset unit_reset", unit_reset, 1'b1);
    check("post-reset grant", grant, '0);

    // Held requests from every requester: grants rotate 0,1,2,3,0.
    req = 4'b1111;
    req_bit = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      collect(k == 4, 4'b0000, r);
      check($sformatf("held%0d done", k), r.seen_done, 1'b1);
      check($sformatf("held%0d grant", k), r.g, 4'b0001 << (k % 4));
      check($sformatf("held%0d out_id", k), r.id, k % 4);
      check($sformatf("held%0d beats", k), r.beats, 8);
      check($sformatf("held%0d bad", k), r.bad, 0);
      if (k > 0) check($sformatf("held%0d gap", k), r.t_clear - prev.t_done, 2);
      prev = r;
    end

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req = vecs[i].req;
      req_bit = vecs[i].req_bit;
      unit_mute = vecs[i].mute;
      t_req = cyc;
      collect(1'b1, 4'b0000, r);
      check($sformatf("row%0d done", i), r.seen_done, 1'b1);
      check($sformatf("row%0d req->clear", i), r.t_clear - t_req, 1);
      check($sformatf("row%0d grant", i), r.g, 4'b0001 << vecs[i].exp_id);
      check($sformatf("row%0d out_id", i), r.id, vecs[i].exp_id);
      check($sformatf("row%0d err", i), r.e, vecs[i].exp_err);
      check($sformatf("row%0d takes", i), r.takes, INPUT_WIDTH);
      check($sformatf("row%0d first take", i), r.t_first - r.t_clear, 1);
      check($sformatf("row%0d take span", i), r.t_last - r.t_first + 1, INPUT_WIDTH);
      check($sformatf("row%0d beats", i), r.beats, vecs[i].exp_beats);
      check($sformatf("row%0d ones", i), r.ones, vecs[i].exp_ones);
      check($sformatf("row%0d latency", i), r.t_done - r.t_clear, vecs[i].exp_lat);
      check($sformatf("row%0d bad", i), r.bad, 0);
    end
    unit_mute = 1'b0;

    // Reset on the 4th STREAM cycle of a stream owned by requester 3.
    @(negedge clk);
    req = 4'b1001;
    req_bit = 4'b1111;
    wait_n = 0;
    while (grant == '0 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("midreset grant", grant, 4'b1000);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    check("midreset outputs", {grant, bit_take, out_bit, out_valid, out_id, done, err,
                               unit_ready, unit_a, unit_reset}, '0);
    reset = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midreset no done", done_cnt, 0);
    check("midreset unit_reset", unit_reset, 1'b1);

    // A fresh request after reset starts from rr_ptr = 0.
    req = 4'b1001;
    t_req = cyc;
    collect(1'b1, 4'b0000, r);
    check("fresh done", r.seen_done, 1'b1);
    check("fresh req->clear", r.t_clear - t_req, 1);
    check("fresh grant", r.g, 4'b0001);
    check("fresh beats", r.beats, 8);
    check("fresh ones", r.ones, 4);
    check("fresh err", r.e, 1'b0);

    // Owner 0 drops its request at CLEAR while requester 2 raises its own.
    @(negedge clk);
    req = 4'b0001;
    collect(1'b1, 4'b0100, prev);
    check("drop done", prev.seen_done, 1'b1);
    check("drop out_id", prev.id, 0);
    check("drop beats", prev.beats, 8);
    check("drop ones", prev.ones, 4);
    collect(1'b1, 4'b0000, r);
    check("next grant", r.g, 4'b0100);
    check("next gap", r.t_clear - prev.t_done, 2);
    check("next out_id", r.id, 2);
    check("next beats", r.beats, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unary_unit_arbiter.md
# unary_unit_arbiter

Shares one bit-serial unary arithmetic unit (divide-by-two class, `a`/`ready`/`valid`/`y` stream interface) between `NUM_REQ` requesters. Round-robin arbitration selects one requester per stream. The block clears the unit, feeds exactly `INPUT_WIDTH` input bits and collects exactly `INPUT_WIDTH` result bits. Results are forwarded, tagged with the owner ID, and the stream is closed with a done pulse. It sits between the requester-side stream sources and a single shared unary unit instance.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `INPUT_WIDTH`, 32, stream length in bits
- `COUNT_WIDTH`, $clog2(INPUT_WIDTH+1), bit/result counter width
- `ID_WIDTH`, $clog2(NUM_REQ), requester index width
- `TIMEOUT`, 4*INPUT_WIDTH, max STREAM cycles before abort
- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  synchronous, active-low
- `req`  in  NUM_REQ  per-requester stream request, level
- `req_bit`  in  NUM_REQ  per-requester unary input bit
- `grant`  out  NUM_REQ  one-hot owner, held for the whole stream
- `bit_take`  out  NUM_REQ  owner's `req_bit` consumed this cycle
- `out_bit`  out  1  result bit
- `out_valid`  out  1  `out_bit` valid
- `out_id`  out  ID_WIDTH  owner index, valid with `out_valid`/`done`
- `done`  out  1  one-cycle end-of-stream pulse
- `err`  out  1  with `done`: stream aborted by timeout
- `unit_reset`  out  1  active-low clear to unit
- `unit_ready`  out  1  unit input strobe
- `unit_a`  out  1  unit input bit
- `unit_valid`  in  1  unit result strobe
- `unit_y`  in  1  unit result bit

## Operation
- FSM states: IDLE, CLEAR, STREAM, DONE.
- IDLE: if `|req`, choose the first set `req` at or after `rr_ptr` (wrapping), register it as the owner, and go to CLEAR. Otherwise stay.
- CLEAR (1 cycle): `grant` is one-hot on the owner. `unit_reset`=0. `in_cnt`, `out_cnt` and `timer` are cleared. Next state is STREAM.
- STREAM:
  - `unit_ready` = (`in_cnt` < INPUT_WIDTH). `unit_a` = `req_bit[owner]`, and `bit_take[owner]` = `unit_ready`. `in_cnt` increments on each take.
  - `unit_valid` increments `out_cnt` and is registered onto `out_bit`/`out_valid`/`out_id`.
  - `timer` increments every cycle.
  - Exit to DONE when `out_cnt` reaches INPUT_WIDTH, counting the current `unit_valid`. Also exit to DONE when `timer` == TIMEOUT-1, which sets `err`.
- DONE (1 cycle): `done`=1, `out_id`=owner, `err` per exit cause. `rr_ptr` becomes owner+1 mod NUM_REQ. `grant` is released. Next state is IDLE.
- Deasserting `req[owner]` mid-stream is ignored. The stream always runs to DONE.
- `unit_valid` outside STREAM is ignored.
- `unit_reset` is 1 in all states except CLEAR, and is 0 while `reset`=0.
- Counters saturate at INPUT_WIDTH and never wrap. `timer` width is $clog2(TIMEOUT+1).

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, counters 0.
  - `grant`, `bit_take`, `out_bit`, `out_valid`, `out_id`, `done`, `err`, `unit_ready` and `unit_a` are all 0.
  - `unit_reset` is 0 during reset and 1 on the first cycle after reset is released.
- A `req` seen in IDLE at cycle T gives CLEAR at T+1 and the first `unit_ready`/`bit_take` at T+2. Input bits occupy T+2..T+1+INPUT_WIDTH, with no gaps.
- `out_valid` lags `unit_valid` by exactly 1 cycle.
- `done` asserts the cycle after the final `out_valid`-source beat. That is the same cycle the last `out_valid` is presented.
- After DONE there is a minimum of 1 IDLE cycle before the next CLEAR. Back-to-back stream period = INPUT_WIDTH-dependent unit latency + 3 cycles.
- Reset asserted mid-stream: all outputs take their reset values on the next edge, and no `done` is emitted.

## Structure
- Package `unary_ctrl_pkg`: `state_t` enum (IDLE, CLEAR, STREAM, DONE) and an `id_width(n)` function returning max(1, $clog2(n)).
- Sub-module `rr_arbiter` (NUM_REQ): inputs `req` and `ptr`; outputs one-hot `gnt`, `gnt_id` and `any`. It is combinational and priority-rotated.
- The top level holds the FSM, counters, timer and output registers.

## Test plan
- INPUT_WIDTH=8, `req`=4'b0001, `req_bit` all 1, unit model instantiated:
  - 8 `bit_take` pulses in consecutive cycles and 8 `out_valid` beats containing exactly 4 ones.
  - `done`=1, `out_id`=0, `err`=0.
- `req_bit` all 0:
  - 8 `out_valid` beats, all 0.
  - `done` with `err`=0.
- `req`=4'b1111 held:
  - grants occur in order 0,1,2,3,0.
  - each `grant` is one-hot, and `done`/`out_id` match it.
- Unit model with `unit_valid` tied 0, TIMEOUT=32:
  - `done`=1 and `err`=1 exactly 32 STREAM cycles after CLEAR.
  - no `out_valid`.
- `reset`=0 on the 4th STREAM cycle:
  - next cycle state is IDLE, all outputs 0, no `done`.
  - a fresh `req` afterwards completes normally.
- Owner drops `req` mid-stream while `req[2]` rises:
  - the current stream completes 8 beats.
  - requester 2 is granted after DONE+IDLE.
